ysyx_22050854_mdu_scheduler: RTL
================================

# ysyx_22050854_mdu_scheduler

Sequencing controller between the EXE stage and the two multi-cycle arithmetic units (shift-add multiplier, shift divider). Accepts one mul/div operation at a time from EXE, latches its operands, issues a single-cycle valid to the selected unit, waits for completion, and returns the selected result with a one-cycle valid. Generates the EXE stall signal and discards results of flushed operations.

## Interface
- XLEN, 64, operand/result width
- CNT_W, 8, latency counter width

- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  EXE holds a valid mul/div op (already qualified with EXE valid)
- req_is_div  in  1  0 = multiplier, 1 = divider
- req_res_sel  in  2  00 mul lo, 01 mul hi, 10 quotient, 11 remainder
- req_ctl  in  4  unit control code (MULctr encoding), passed through
- req_src1, req_src2  in  XLEN  operands
- flush  in  1  kill the in-flight op
- mul_ready, mul_doing, mul_out_valid  in  1  multiplier status
- mul_result_hi, mul_result_lo  in  XLEN  multiplier results
- div_ready, div_doing, div_out_valid  in  1  divider status
- div_quotient, div_remainder  in  XLEN  divider results
- mul_valid, div_valid  out  1  single-cycle issue strobes
- op_ctl  out  4  latched req_ctl
- op_src1, op_src2  out  XLEN  latched operands
- busy  out  1  stall EXE
- res_valid  out  1  result valid, one cycle
- res_data  out  XLEN  selected result
- last_latency  out  CNT_W  issue-to-result cycles of last completed op

## Operation
- States: IDLE, ISSUE, WAIT, DONE, DRAIN.
- IDLE: req_valid && !flush -> latch req_* into op registers, -> ISSUE.
- ISSUE: assert selected unit valid when its ready && !doing && !flush; next cycle -> WAIT. If unit not ready, hold ISSUE. flush -> IDLE, no strobe issued.
- WAIT: on selected unit out_valid capture result per latched res_sel into res register, -> DONE. flush (without out_valid) -> DRAIN; flush with out_valid same cycle -> IDLE, result dropped.
- DONE: res_valid=1 for exactly one cycle, -> IDLE. flush in DONE suppresses res_valid.
- DRAIN: wait for selected unit out_valid, discard, -> IDLE. New requests stall meanwhile.
- busy = req_valid && state != DONE (combinational); busy=0 whenever flush=1.
- The non-selected unit's strobe is never asserted; out_valid from the non-selected unit is ignored.
- Latency counter clears on ISSUE entry, increments each cycle in ISSUE/WAIT, saturates at 2^CNT_W-1; copied to last_latency on DONE entry (not on flush/drain).
- Reset (any time, including mid-op): state IDLE, all outputs 0, op registers 0, last_latency 0, result register 0.

## Timing
- Request first seen in IDLE at cycle t: unit strobe at t+1 (if ready), out_valid at t+1+L, res_valid at t+2+L, busy high t..t+1+L, low at t+2+L.
- Strobe width exactly 1 cycle per op; never reasserted for the same op.
- res_data stable from DONE until next WAIT capture.
- Back-to-back ops: second op's IDLE cycle follows DONE; minimum 1 idle cycle between res_valid and next strobe.

## Structure
- Package ysyx_22050854_mdu_pkg: state enum, res_sel encodings, XLEN default.
- Sub-module ysyx_22050854_sat_counter (parameterised width, clear/enable, saturating) for the latency counter.

## Test plan
- mul, src1=3, src2=-5, res_sel=00, L=64 -> mul_valid pulse at t+1, res_valid at t+66, res_data=-15, last_latency=65.
- div, src1=100, src2=7, res_sel=11, div_ready low 3 cycles -> div_valid delayed to t+4, res_data=2, busy low only in DONE.
- flush during WAIT of div -> DRAIN, divider out_valid discarded, no res_valid, next mul request stalls until drain ends.
- flush in ISSUE same cycle as ready -> no strobe, state IDLE next cycle.
- reset asserted mid-WAIT -> all outputs 0 asynchronously, state IDLE; late out_valid after reset ignored.
- two consecutive mul ops (hi then lo of 0xFFFF_FFFF_FFFF_FFFF × 2, unsigned) -> res_data 1 then 0xFFFF_FFFF_FFFF_FFFE, exactly one strobe each.

Source files
------------

// File: rtl/ysyx_22050854_mdu_pkg.sv
// Shared types and constants for the mul/div scheduler.
//   mdu_state_e : scheduler FSM states
//   res_sel_e   : result selector encoding (which unit output is returned)
//   XlenDefault : default operand/result width
package ysyx_22050854_mdu_pkg;

  localparam int unsigned XlenDefault = 64;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWait,
    StDone,
    StDrain
  } mdu_state_e;

  typedef enum logic [1:0] {
    ResMulLo = 2'b00,
    ResMulHi = 2'b01,
    ResQuot  = 2'b10,
    ResRem   = 2'b11
  } res_sel_e;

endpackage

// File: rtl/ysyx_22050854_sat_counter.sv
// Saturating up-counter with synchronous clear and count enable.
// Ports:
//   i_clock, i_reset : clock, asynchronous active-high reset
//   i_clear          : force count to zero at the next edge (wins over enable)
//   i_enable         : increment at the next edge, holding at all-ones
//   o_count_next     : value the counter takes at the next edge
module ysyx_22050854_sat_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_clear,
  input  logic             i_enable,
  output logic [WIDTH-1:0] o_count_next
);

  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] w_count_next;

  always_comb begin
    w_count_next = r_count;
    if (i_clear) begin
      w_count_next = '0;
    end else if (i_enable && (r_count != {WIDTH{1'b1}})) begin
      w_count_next = r_count + WIDTH'(1);
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_count <= '0;
    end else begin
      r_count <= w_count_next;
    end
  end

  // Exposing the next value lets the owner snapshot the count including the
  // cycle in which the snapshot is taken.
  assign o_count_next = w_count_next;

endmodule

// File: rtl/ysyx_22050854_mdu_scheduler.sv
// Sequencer between EXE and the multi-cycle multiplier / divider.
// Accepts one op, latches operands, issues a one-cycle strobe to the selected
// unit, waits for its result and returns it with a one-cycle valid.
// Ports:
//   i_clock, i_reset            : clock, asynchronous active-high reset
//   i_req_*                     : op request from EXE (valid, unit, result select,
//                                 control code, operands)
//   i_flush                     : kill the in-flight op
//   i_mul_* / i_div_*           : unit status and results
//   o_mul_valid, o_div_valid    : issue strobes
//   o_op_ctl, o_op_src1/2       : latched control code and operands for the units
//   o_busy                      : EXE stall
//   o_res_valid, o_res_data     : returned result
//   o_last_latency              : issue-to-result cycles of the last completed op
module ysyx_22050854_mdu_scheduler
  import ysyx_22050854_mdu_pkg::*;
#(
  parameter int unsigned XLEN  = XlenDefault,
  parameter int unsigned CNT_W = 8
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_req_valid,
  input  logic             i_req_is_div,
  input  logic [1:0]       i_req_res_sel,
  input  logic [3:0]       i_req_ctl,
  input  logic [XLEN-1:0]  i_req_src1,
  input  logic [XLEN-1:0]  i_req_src2,
  input  logic             i_flush,
  input  logic             i_mul_ready,
  input  logic             i_mul_doing,
  input  logic             i_mul_out_valid,
  input  logic [XLEN-1:0]  i_mul_result_hi,
  input  logic [XLEN-1:0]  i_mul_result_lo,
  input  logic             i_div_ready,
  input  logic             i_div_doing,
  input  logic             i_div_out_valid,
  input  logic [XLEN-1:0]  i_div_quotient,
  input  logic [XLEN-1:0]  i_div_remainder,
  output logic             o_mul_valid,
  output logic             o_div_valid,
  output logic [3:0]       o_op_ctl,
  output logic [XLEN-1:0]  o_op_src1,
  output logic [XLEN-1:0]  o_op_src2,
  output logic             o_busy,
  output logic             o_res_valid,
  output logic [XLEN-1:0]  o_res_data,
  output logic [CNT_W-1:0] o_last_latency
);

  mdu_state_e       r_state;
  mdu_state_e       w_state_next;
  logic             r_is_div;
  res_sel_e         r_res_sel;
  logic [3:0]       r_ctl;
  logic [XLEN-1:0]  r_src1;
  logic [XLEN-1:0]  r_src2;
  logic [XLEN-1:0]  r_res;
  logic [CNT_W-1:0] r_last_lat;

  logic             w_accept;
  logic             w_issue;
  logic             w_capture;
  logic             w_cnt_clear;
  logic             w_cnt_enable;
  logic             w_sel_ready;
  logic             w_sel_out_valid;
  logic [XLEN-1:0]  w_sel_result;
  logic [CNT_W-1:0] w_cnt_next;

  // Only the latched unit is considered; the other unit's status is ignored.
  assign w_sel_ready     = r_is_div ? (i_div_ready && !i_div_doing)
                                    : (i_mul_ready && !i_mul_doing);
  assign w_sel_out_valid = r_is_div ? i_div_out_valid : i_mul_out_valid;

  always_comb begin
    w_sel_result = i_mul_result_lo;
    unique case (r_res_sel)
      ResMulLo: w_sel_result = i_mul_result_lo;
      ResMulHi: w_sel_result = i_mul_result_hi;
      ResQuot:  w_sel_result = i_div_quotient;
      ResRem:   w_sel_result = i_div_remainder;
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_issue      = 1'b0;
    w_capture    = 1'b0;
    w_cnt_clear  = 1'b0;
    w_cnt_enable = 1'b0;
    o_res_valid  = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (i_req_valid && !i_flush) begin
          w_accept     = 1'b1;
          w_cnt_clear  = 1'b1;
          w_state_next = StIssue;
        end
      end
      StIssue: begin
        w_cnt_enable = 1'b1;
        if (i_flush) begin
          w_state_next = StIdle;
        end else if (w_sel_ready) begin
          w_issue      = 1'b1;
          w_state_next = StWait;
        end
      end
      StWait: begin
        w_cnt_enable = 1'b1;
        if (w_sel_out_valid) begin
          // A flush coinciding with the result drops it; nothing left to drain.
          if (i_flush) begin
            w_state_next = StIdle;
          end else begin
            w_capture    = 1'b1;
            w_state_next = StDone;
          end
        end else if (i_flush) begin
          w_state_next = StDrain;
        end
      end
      StDone: begin
        o_res_valid  = !i_flush;
        w_state_next = StIdle;
      end
      StDrain: begin
        if (w_sel_out_valid) begin
          w_state_next = StIdle;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state    <= StIdle;
      r_is_div   <= 1'b0;
      r_res_sel  <= ResMulLo;
      r_ctl      <= '0;
      r_src1     <= '0;
      r_src2     <= '0;
      r_res      <= '0;
      r_last_lat <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_is_div  <= i_req_is_div;
        r_res_sel <= res_sel_e'(i_req_res_sel);
        r_ctl     <= i_req_ctl;
        r_src1    <= i_req_src1;
        r_src2    <= i_req_src2;
      end
      if (w_capture) begin
        r_res      <= w_sel_result;
        r_last_lat <= w_cnt_next;
      end
    end
  end

  ysyx_22050854_sat_counter #(
    .WIDTH (CNT_W)
  ) u_lat_cnt (
    .i_clock      (i_clock),
    .i_reset      (i_reset),
    .i_clear      (w_cnt_clear),
    .i_enable     (w_cnt_enable),
    .o_count_next (w_cnt_next)
  );

  assign o_mul_valid    = w_issue && !r_is_div;
  assign o_div_valid    = w_issue && r_is_div;
  assign o_op_ctl       = r_ctl;
  assign o_op_src1      = r_src1;
  assign o_op_src2      = r_src2;
  assign o_res_data     = r_res;
  assign o_last_latency = r_last_lat;
  // Reset is folded in so the stall drops immediately, not at the next edge.
  assign o_busy = i_req_valid && !i_flush && !i_reset && (r_state != StDone);

endmodule
